// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Stream framing: length bytes, little-endian words, and a mod-256 checksum.
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int CSUM_W         = 8;

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and pulses word_valid
// for one cycle after the last byte of each word has been accepted.
module word_assembler
    import loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [IDX_W-1:0] byte_idx,
    output logic             word_valid,
    output logic [31:0]      word_data
);

    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      word_reg;
    logic [31:0]      word_next;
    logic             valid_reg;

    // Shift right by one lane; the newest byte lands in the top lane so the
    // first byte of the word ends up least significant.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == BYTES_PER_WORD - 1) begin : g_top
                assign word_next[8*gi +: 8] = byte_data;
            end else begin : g_shift
                assign word_next[8*gi +: 8] = word_reg[8*(gi+1) +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx_reg   <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= byte_valid && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
            if (byte_valid) begin
                word_reg <= word_next;
                idx_reg  <= idx_reg + 1'b1;
            end
        end
    end

    assign byte_idx   = idx_reg;
    assign word_valid = valid_reg;
    assign word_data  = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Writes instruction memory from a length-prefixed, checksummed byte stream and
// keeps the core in reset until a complete, verified image has been stored.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t              state_reg;
    state_t              state_next;
    logic [7:0]          len_lo_reg;
    logic [15:0]         len_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [15:0]         word_count_reg;
    logic [CSUM_W-1:0]   sum_reg;
    logic [IDX_W-1:0]    byte_idx;
    logic [15:0]         len_full;
    logic                accept;
    logic                restart;
    logic                data_accept;
    logic                word_last_byte;

    assign in_ready       = (state_reg != S_DONE) && (state_reg != S_ERR);
    assign accept         = in_valid && in_ready;
    assign restart        = start && ((state_reg == S_DONE) || (state_reg == S_ERR));
    assign data_accept    = accept && (state_reg == S_DATA);
    assign word_last_byte = data_accept && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign len_full       = {in_data, len_lo_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_LEN_LO;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LEN_LO: if (accept) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_full} > DEPTH) begin
                        state_next = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_last_byte && (word_count_reg + 16'd1 == len_reg)) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (in_data == sum_reg) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: if (start) state_next = S_LEN_LO;
            default: state_next = S_LEN_LO;
        endcase
    end

    // The write address is latched with the last byte so it lines up with the
    // registered word_valid pulse from the assembler.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            len_lo_reg     <= '0;
            len_reg        <= '0;
            addr_reg       <= '0;
            mem_addr_reg   <= '0;
            word_count_reg <= '0;
            sum_reg        <= '0;
        end else begin
            if (accept && (state_reg == S_LEN_LO)) begin
                len_lo_reg <= in_data;
            end
            if (accept && (state_reg == S_LEN_HI)) begin
                len_reg <= len_full;
            end
            if (data_accept) begin
                sum_reg <= sum_reg + in_data;
            end
            if (word_last_byte) begin
                mem_addr_reg   <= addr_reg;
                addr_reg       <= addr_reg + 1'b1;
                word_count_reg <= word_count_reg + 16'd1;
            end
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (data_accept),
        .byte_data  (in_data),
        .byte_idx   (byte_idx),
        .word_valid (mem_we),
        .word_data  (mem_wdata)
    );

    assign mem_addr   = mem_addr_reg;
    assign word_count = word_count_reg;
    assign cpu_reset  = (state_reg != S_DONE);
    assign done       = (state_reg == S_DONE);
    assign error      = (state_reg == S_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes RISC-V instruction memory from a byte stream while holding the core in reset. The processor top only reads instruction memory (pc → instr); this block is the write side of that memory. It sits between a host byte source (UART RX or testbench) and the instruction-memory write port. It releases `cpu_reset` only after a complete, checksum-verified image is stored.

## Interface
- `ADDR_W`, default 10: instruction-memory word-address width; depth = 2**ADDR_W words.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous, active-high.
- `start  in  1`: single-cycle pulse; restarts a load from DONE or ERR. Ignored in other states.
- `in_valid  in  1`: byte available.
- `in_data  in  8`: byte value.
- `in_ready  out  1`: loader accepts a byte; transfer occurs when `in_valid && in_ready` at a rising edge.
- `mem_we  out  1`: instruction-memory write strobe, one cycle per word.
- `mem_addr  out  ADDR_W`: word address for the write.
- `mem_wdata  out  32`: instruction word.
- `cpu_reset  out  1`: holds the processor in reset while high.
- `done  out  1`: image loaded and verified.
- `error  out  1`: load failed (length too large or checksum mismatch).
- `word_count  out  16`: number of words written in the current or last load.

## Operation
- Stream format: `LEN_LO`, `LEN_HI` (N words, little-endian, 16 bit), then 4·N payload bytes (each word little-endian, lowest address first), then a 1-byte checksum `CSUM`.
- `CSUM` = sum of all payload bytes mod 256. Length bytes are excluded.
- FSM states: `S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CSUM`, `S_DONE`, `S_ERR`.
- S_LEN_LO → S_LEN_HI on accept.
- S_LEN_HI on accept:
  - N > 2**ADDR_W → S_ERR.
  - N == 0 → S_CSUM.
  - Otherwise → S_DATA.
- S_DATA: a 2-bit byte index packs bytes into a 32-bit shift register. On the 4th byte, issue a write at the current word address, increment the address, and increment `word_count`. After word N, go to S_CSUM.
- S_CSUM: accepted byte equals the running sum → S_DONE; otherwise → S_ERR.
- S_DONE / S_ERR: `start` → S_LEN_LO. On restart, clear address, byte index, sum, `word_count`, `done` and `error`, and assert `cpu_reset`.
- `in_ready` = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CSUM; 0 in S_DONE and S_ERR. No other backpressure; the memory accepts one write per cycle.
- Bytes presented while `in_ready` = 0 are not consumed.
- `cpu_reset` = 0 only in S_DONE.
- Memory already written before an error is left as is; the core stays in reset.

## Timing
- Reset values: FSM = S_LEN_LO, `in_ready` = 1, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_reset` = 1, `done` = 0, `error` = 0, `word_count` = 0.
- Reset asserted mid-load aborts immediately. The next edge yields the reset values; the partial image is not re-validated.
- Write latency: the 4th byte of word k is accepted at edge t. `mem_we` = 1 with `mem_addr` = k and the full word is visible after edge t (registered), for exactly one cycle.
- Back-to-back bytes sustain 1 byte/cycle; `mem_we` pulses at most every 4th cycle.
- The checksum byte is accepted at edge t. After edge t, `done` or `error` = 1 and `in_ready` = 0. `cpu_reset` falls after edge t on success.
- `start` at edge t in DONE/ERR: after edge t, state = S_LEN_LO, `cpu_reset` = 1 and `in_ready` = 1.
- Address wrap: cannot occur, since N ≤ 2**ADDR_W is enforced. N == 2**ADDR_W is legal; the last address is 2**ADDR_W−1.
- The running sum and the byte index update in the same cycle the byte is accepted. The sum is 8-bit and wraps.

## Structure
- `loader_pkg`: FSM state enum, `LEN_BYTES` = 2, `BYTES_PER_WORD` = 4, and a checksum-width constant.
- One sub-module, `word_assembler`: byte index, 32-bit packing register, and a `word_valid` pulse. The FSM, address counter, checksum and flags stay in `imem_loader`.

## Test plan
- Nominal load: bytes 02 00 93 00 50 00 13 01 10 00 07 at 1/cycle → writes (0, 0x00500093) and (1, 0x00100113). `done` = 1, `cpu_reset` = 0, `word_count` = 2.
- Bad checksum: same stream with last byte 0x08 → both writes occur, `error` = 1, `cpu_reset` stays 1, `in_ready` = 0.
- Zero length: 00 00 00 → no `mem_we`, `done` = 1, `word_count` = 0.
- Oversize (ADDR_W = 2): length bytes 05 00 → `error` = 1 right after LEN_HI, no writes.
- Gapped stream: nominal stream with `in_valid` randomly low → identical writes and result. Bytes offered in S_DONE are not consumed.
- Restart and abort:
  - `start` after an error, then the nominal stream → `done` = 1.
  - `reset` mid-payload, then the nominal stream → correct image, `word_count` = 2.
